// File: rtl/pif_led_pkg.sv
// Shared LED colour and decoder FSM encodings for the pif_flasher / pif_led_decoder pair.
package pif_led_pkg;

  // Colour is {red, green}
  typedef enum logic [1:0] {
    LED_OFF   = 2'b00,
    LED_GREEN = 2'b01,
    LED_RED   = 2'b10,
    LED_AMBER = 2'b11
  } led_col_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } led_state_t;

endpackage

// File: rtl/pif_sync2.sv
// Two-flop synchronizer for a single asynchronous level, synchronous reset to 0.
module pif_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pif_led_decoder.sv
// Decodes red/green LED blink bursts into a registered colour + pulse-count code,
// filtering short glitches and ending a burst after a run of off-cycles.
module pif_led_decoder
  import pif_led_pkg::*;
#(
  parameter int unsigned MIN_ON_CYCLES = 4,
  parameter int unsigned GAP_CYCLES    = 16,
  parameter int unsigned CNT_W         = 4
) (
  input  logic             xclk,
  input  logic             sys_rst,
  input  logic             red,
  input  logic             green,
  output logic             code_valid,
  output logic [1:0]       code_color,
  output logic [CNT_W-1:0] code_count,
  output logic             code_err,
  output logic             busy
);

  localparam int unsigned ON_W  = $clog2(MIN_ON_CYCLES + 1);
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [ON_W-1:0]  ON_MAX  = ON_W'(MIN_ON_CYCLES);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_CYCLES);

  logic             red_s;
  logic             green_s;
  led_col_t         col;
  led_state_t       state;
  led_col_t         burst_col;
  logic [ON_W-1:0]  on_ctr;
  logic [GAP_W-1:0] gap_ctr;
  logic [CNT_W-1:0] pcnt;
  logic             err;

  pif_sync2 u_sync_red (
    .clk (xclk),
    .rst (sys_rst),
    .d   (red),
    .q   (red_s)
  );

  pif_sync2 u_sync_green (
    .clk (xclk),
    .rst (sys_rst),
    .d   (green),
    .q   (green_s)
  );

  assign col  = led_col_t'({red_s, green_s});
  assign busy = (state != ST_IDLE);

  always_ff @(posedge xclk) begin
    if (sys_rst) begin
      state      <= ST_IDLE;
      burst_col  <= LED_OFF;
      on_ctr     <= '0;
      gap_ctr    <= '0;
      pcnt       <= '0;
      err        <= 1'b0;
      code_valid <= 1'b0;
      code_color <= '0;
      code_count <= '0;
      code_err   <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (col != LED_OFF) begin
            state     <= ST_ON;
            on_ctr    <= ON_W'(1);
            burst_col <= col;
            pcnt      <= '0;
            err       <= 1'b0;
          end
        end

        ST_ON: begin
          if (col == LED_OFF) begin
            if (on_ctr >= ON_MAX) begin
              if (pcnt == '1) begin
                err <= 1'b1;
              end else begin
                pcnt <= pcnt + 1'b1;
              end
            end
            state   <= ST_GAP;
            gap_ctr <= GAP_W'(1);
          end else begin
            if (col != burst_col) begin
              err <= 1'b1;
            end
            if (on_ctr < ON_MAX) begin
              on_ctr <= on_ctr + 1'b1;
            end
          end
        end

        ST_GAP: begin
          // Termination is checked before col so an off-run of exactly GAP_CYCLES
          // ends the burst even if the line comes back on at that same edge.
          if (gap_ctr == GAP_MAX) begin
            state <= ST_IDLE;
            if (pcnt != '0) begin
              code_valid <= 1'b1;
              code_color <= burst_col;
              code_count <= pcnt;
              code_err   <= err;
            end
          end else if (col != LED_OFF) begin
            state  <= ST_ON;
            on_ctr <= ON_W'(1);
            if (col != burst_col) begin
              err <= 1'b1;
            end
          end else begin
            gap_ctr <= gap_ctr + 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pif_led_decoder.sv
// Directed-vector bench for pif_led_decoder (MIN_ON=4, GAP=16, CNT_W=4).
module tb_pif_led_decoder;

  logic       xclk;
  logic       sys_rst;
  logic       red;
  logic       green;
  logic       code_valid;
  logic [1:0] code_color;
  logic [3:0] code_count;
  logic       code_err;
  logic       busy;

  int n_checks;
  int n_fail;
  int cyc;
  int n_codes;
  int b2b;
  logic prev_v;
  int   s_cyc [0:63];
  logic [3:0] s_cnt [0:63];
  logic [1:0] s_col [0:63];

  pif_led_decoder #(
    .MIN_ON_CYCLES (4),
    .GAP_CYCLES    (16),
    .CNT_W         (4)
  ) dut (
    .xclk       (xclk),
    .sys_rst    (sys_rst),
    .red        (red),
    .green      (green),
    .code_valid (code_valid),
    .code_color (code_color),
    .code_count (code_count),
    .code_err   (code_err),
    .busy       (busy)
  );

  initial xclk = 1'b0;
  always #5 xclk = ~xclk;

  initial cyc = 0;
  always @(posedge xclk) cyc++;

  initial begin
    n_codes = 0;
    b2b     = 0;
    prev_v  = 1'b0;
  end

  always @(negedge xclk) begin
    if (code_valid === 1'b1) begin
      if (prev_v) b2b++;
      if (n_codes < 64) begin
        s_cyc[n_codes] = cyc;
        s_cnt[n_codes] = code_count;
        s_col[n_codes] = code_color;
      end
      n_codes++;
    end
    prev_v = (code_valid === 1'b1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive the LED lines for n cycles; entry and exit are 1 time unit after a posedge.
  task automatic hold(input logic r, input logic g, input int n);
    red   = r;
    green = g;
    repeat (n) @(posedge xclk);
    #1;
  endtask

  int base;
  int fall;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    sys_rst  = 1'b1;
    red      = 1'b0;
    green    = 1'b0;
    repeat (3) @(posedge xclk);
    #1;
    check_eq("rst_valid", code_valid, 0);
    check_eq("rst_color", code_color, 0);
    check_eq("rst_count", code_count, 0);
    check_eq("rst_err",   code_err,   0);
    check_eq("rst_busy",  busy,       0);
    sys_rst = 1'b0;
    hold(0, 0, 4);

    // Three red pulses 8 on / 8 off
    base = n_codes;
    hold(1, 0, 8);
    check_eq("s1_busy_mid", busy, 1);
    hold(0, 0, 8);
    hold(1, 0, 8);
    hold(0, 0, 8);
    hold(1, 0, 8);
    hold(0, 0, 40);
    check_eq("s1_ncodes", n_codes - base, 1);
    check_eq("s1_color",  code_color, 2'b10);
    check_eq("s1_count",  code_count, 3);
    check_eq("s1_err",    code_err,   0);
    check_eq("s1_busy",   busy,       0);

    // Green glitch of 3 cycles: nothing emitted, previous code held
    base = n_codes;
    hold(0, 1, 3);
    hold(0, 0, 40);
    check_eq("s2_glitch_ncodes", n_codes - base, 0);
    check_eq("s2_glitch_busy",   busy, 0);
    check_eq("s2_hold_count",    code_count, 3);

    // Green 4 cycles: exactly at the pulse threshold
    base = n_codes;
    hold(0, 1, 4);
    hold(0, 0, 40);
    check_eq("s2_ncodes", n_codes - base, 1);
    check_eq("s2_color",  code_color, 2'b01);
    check_eq("s2_count",  code_count, 1);
    check_eq("s2_err",    code_err,   0);

    // Red then green within one burst: colour mismatch
    base = n_codes;
    hold(1, 0, 8);
    hold(0, 0, 8);
    hold(0, 1, 8);
    hold(0, 0, 40);
    check_eq("s3_ncodes", n_codes - base, 1);
    check_eq("s3_color",  code_color, 2'b10);
    check_eq("s3_count",  code_count, 2);
    check_eq("s3_err",    code_err,   1);

    // 17 amber pulses: counter saturates at 15 and flags error
    base = n_codes;
    for (int i = 0; i < 17; i++) begin
      hold(1, 1, 6);
      hold(0, 0, 6);
    end
    hold(0, 0, 34);
    check_eq("s4_ncodes", n_codes - base, 1);
    check_eq("s4_color",  code_color, 2'b11);
    check_eq("s4_count",  code_count, 15);
    check_eq("s4_err",    code_err,   1);

    // Gap of 15 off-cycles keeps one burst
    base = n_codes;
    hold(1, 0, 8);
    hold(0, 0, 15);
    hold(1, 0, 8);
    hold(0, 0, 40);
    check_eq("gap15_ncodes", n_codes - base, 1);
    check_eq("gap15_count",  code_count, 2);

    // Gap of 16 off-cycles splits into two bursts
    base = n_codes;
    hold(1, 0, 8);
    fall = cyc;
    hold(0, 0, 16);
    hold(1, 0, 8);
    hold(0, 0, 40);
    check_eq("gap16_ncodes", n_codes - base, 2);
    check_eq("gap16_cnt0",   s_cnt[base],     1);
    check_eq("gap16_cnt1",   s_cnt[base + 1], 1);
    check_eq("gap16_col1",   s_col[base + 1], 2'b10);
    // Input drop -> col low after 2 syncs, FSM sees it 1 edge later, +16 gap edges.
    check_eq("gap16_strobe_time", s_cyc[base] - fall, 19);

    // Reset during the second of three red pulses aborts that burst
    base = n_codes;
    hold(1, 0, 8);
    hold(0, 0, 8);
    hold(1, 0, 1);
    sys_rst = 1'b1;
    hold(1, 0, 1);
    sys_rst = 1'b0;
    check_eq("rst_mid_valid", code_valid, 0);
    check_eq("rst_mid_color", code_color, 0);
    check_eq("rst_mid_count", code_count, 0);
    check_eq("rst_mid_err",   code_err,   0);
    check_eq("rst_mid_busy",  busy,       0);
    hold(1, 0, 6);
    hold(0, 0, 8);
    hold(1, 0, 8);
    hold(0, 0, 40);
    // Only the post-reset fragment (rest of pulse 2 + pulse 3) decodes
    check_eq("rst_tail_ncodes", n_codes - base, 1);
    check_eq("rst_tail_count",  code_count, 2);
    check_eq("rst_tail_color",  code_color, 2'b10);

    base = n_codes;
    hold(1, 1, 8);
    hold(0, 0, 40);
    check_eq("amber_ncodes", n_codes - base, 1);
    check_eq("amber_color",  code_color, 2'b11);
    check_eq("amber_count",  code_count, 1);
    check_eq("amber_err",    code_err,   0);
    check_eq("amber_busy",   busy,       0);

    check_eq("no_back_to_back", b2b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
